// File: rtl/seq_slice_adder.sv
// Multi-cycle ripple adder: SLICE bits per clock, LSB first; optional subtract via SEQ_ADDER_SUB_EN.
// Latency: start accepted in cycle 0 -> done pulse in cycle NSLICE+1.
// Backpressure: ready=0 while running; start is ignored (not queued) until IDLE/DONE.
module seq_slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [SLICE:0]   slice_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] res_next;

    // Subtraction is A + ~B + 1; the inversion is applied once at capture time.
    always_comb begin
`ifdef SEQ_ADDER_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : c_in;
`else
        b_eff   = b;
        cin_eff = c_in;
`endif
    end

    // Operands shift right each cycle so the active slice always sits in the low bits.
    always_comb begin
        slice_sum = {1'b0, op_a[SLICE-1:0]} + {1'b0, op_b[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
        msb_cin   = op_a[SLICE-1] ^ op_b[SLICE-1] ^ slice_sum[SLICE-1];
        res_next  = (res >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_eff;
                        carry <= cin_eff;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= RUN;
                    end else begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> SLICE;
                    op_b  <= op_b >> SLICE;
                    res   <= res_next;
                    carry <= slice_sum[SLICE];
                    if (cnt == LAST) begin
                        // msb_cin is only meaningful here, where the current slice holds bit WIDTH-1.
                        sum   <= res_next;
                        c_out <= slice_sum[SLICE];
                        ovf   <= msb_cin ^ slice_sum[SLICE];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Randomized and directed bench for seq_slice_adder against an integer-arithmetic model.
module tb_seq_slice_adder;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int LAT = NSLICE + 1;
`ifdef SEQ_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SEQ_ADDER_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;

    seq_slice_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef SEQ_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed range for overflow.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic cin,
                                  input logic do_sub, output logic [15:0] s,
                                  output logic co, output logic ov);
        int ux, uy, sx, sy, ur, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (do_sub) begin
            ur = ux - uy;
            sr = sx - sy;
            co = (ur >= 0);
        end else begin
            ur = ux + uy + int'(cin);
            sr = sx + sy + int'(cin);
            co = (ur > 65535);
        end
        s  = ur[15:0];
        ov = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                         input logic isub);
        a    = ia;
        b    = ib;
        c_in = icin;
`ifdef SEQ_ADDER_SUB_EN
        sub  = isub;
`endif
    endtask

    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic isub);
        logic [15:0] es, held;
        logic        eco, eov;
        int          lat;
        bit          stable;
        model(ia, ib, icin, isub, es, eco, eov);
        drive(ia, ib, icin, isub);
        start = 1'b1;
        tick();
        start = 1'b0;
        held   = sum;
        stable = 1'b1;
        lat    = 1;
        check("busy_ready", 32'(ready), 32'd0);
        while (!done && lat < 20) begin
            if (sum !== held) stable = 1'b0;
            tick();
            lat++;
        end
        check("latency", lat, LAT);
        check("no_partial", 32'(stable), 32'd1);
        check("sum", 32'(sum), 32'(es));
        check("c_out", 32'(c_out), 32'(eco));
        check("ovf", 32'(ovf), 32'(eov));
        check("done_ready", 32'(ready), 32'd1);
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] es, es2, got_sum;
        logic        eco, eov, eco2, eov2;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          ndone, gap;

        rst   = 1'b1;
        start = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0);

        // Reset held two cycles
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        tick();

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);

        // start pulsed during cycles 2-3 of a run must be ignored
        model(16'hABCD, 16'h1111, 1'b1, 1'b0, es, eco, eov);
        drive(16'hABCD, 16'h1111, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        drive(16'h5A5A, 16'hA5A5, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        ndone = 0;
        got_sum = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) begin
                ndone++;
                got_sum = sum;
            end
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_sum", 32'(got_sum), 32'(es));

        // start held high through DONE: back-to-back acceptance
        model(16'h0F0F, 16'h00F1, 1'b0, 1'b0, es, eco, eov);
        model(16'h8001, 16'h8001, 1'b1, 1'b0, es2, eco2, eov2);
        drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        start = 1'b1;
        gap = 0;
        tick();
        while (!done && gap < 20) begin
            tick();
            gap++;
        end
        check("b2b_first_sum", 32'(sum), 32'(es));
        drive(16'h8001, 16'h8001, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        gap = 1;
        while (!done && gap < 20) begin
            tick();
            gap++;
        end
        check("b2b_gap", gap, LAT);
        check("b2b_sum", 32'(sum), 32'(es2));
        check("b2b_cout", 32'(c_out), 32'(eco2));
        check("b2b_ovf", 32'(ovf), 32'(eov2));
        tick();

        // Reset in cycle 3 of a run aborts it
        drive(16'h2222, 16'h3333, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(c_out), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_ndone", ndone, 0);
        run_op(16'h2222, 16'h3333, 1'b0, 1'b0);

        if (HAS_SUB) begin
            run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
            run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        end

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = HAS_SUB ? 1'($urandom) : 1'b0;
            run_op(ra, rb, rc, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
